// File: rtl/rob_unit.sv
// rob_unit: 32-entry reorder buffer with dual-CDB writeback, operand lookup and in-order retire.
// Optional ROB_BYPASS_EN forwards same-cycle CDB broadcasts to the lookup ports.
module rob_unit #(
    parameter int         DEPTH       = 32,
    parameter logic [5:0] INVALID_TAG = 6'b100000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        alloc_valid,
    input  logic [4:0]  alloc_rd,
    output logic        alloc_ready,
    output logic [5:0]  alloc_tag,
    input  logic        cdb_valid,
    input  logic [5:0]  cdb_tag,
    input  logic [31:0] cdb_data,
    input  logic        cdb2_valid,
    input  logic [5:0]  cdb2_tag,
    input  logic [31:0] cdb2_data,
    input  logic [5:0]  lk1_tag,
    input  logic [5:0]  lk2_tag,
    output logic        lk1_ready,
    output logic        lk2_ready,
    output logic [31:0] lk1_value,
    output logic [31:0] lk2_value,
    output logic        commit_valid,
    output logic [4:0]  commit_rd,
    output logic [5:0]  commit_tag,
    output logic [31:0] commit_data,
    output logic [5:0]  count,
    output logic        empty
);
    logic [DEPTH-1:0] busy, rdy;
    logic [4:0]       rd_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [4:0]       head, tail;
    logic             do_alloc, do_commit, wb1, wb2;

    assign alloc_ready = count < 6'(DEPTH);
    assign alloc_tag   = {1'b0, tail};
    assign empty       = count == 6'd0;
    assign do_alloc    = alloc_valid && alloc_ready;
    assign do_commit   = busy[head] && rdy[head];
    // Only a busy, still-pending entry accepts a result; freshly allocated slots are not busy yet.
    assign wb1 = cdb_valid && !cdb_tag[5] && busy[cdb_tag[4:0]] && !rdy[cdb_tag[4:0]];
    assign wb2 = cdb2_valid && !cdb2_tag[5] && busy[cdb2_tag[4:0]] && !rdy[cdb2_tag[4:0]];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy         <= '0;
            rdy          <= '0;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            commit_valid <= 1'b0;
            commit_rd    <= '0;
            commit_tag   <= INVALID_TAG;
            commit_data  <= '0;
        end else if (flush) begin
            busy         <= '0;
            rdy          <= '0;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            commit_valid <= 1'b0;
        end else begin
            commit_valid <= do_commit;
            if (wb2) rdy[cdb2_tag[4:0]] <= 1'b1;
            if (wb1) rdy[cdb_tag[4:0]] <= 1'b1;
            if (do_commit) begin
                busy[head]  <= 1'b0;
                commit_rd   <= rd_q[head];
                commit_tag  <= {1'b0, head};
                commit_data <= data_q[head];
                head        <= head + 5'd1;
            end
            if (do_alloc) begin
                busy[tail] <= 1'b1;
                rdy[tail]  <= 1'b0;
                tail       <= tail + 5'd1;
            end
            count <= count + 6'(do_alloc) - 6'(do_commit);
        end
    end

    // Payload needs no reset: lookups and commits only expose it once the ready bit is set.
    always_ff @(posedge clock) begin
        if (!flush) begin
            if (wb2) data_q[cdb2_tag[4:0]] <= cdb2_data;
            if (wb1) data_q[cdb_tag[4:0]] <= cdb_data;
            if (do_alloc) begin
                data_q[tail] <= '0;
                rd_q[tail]   <= alloc_rd;
            end
        end
    end

    function automatic logic [32:0] lookup(input logic [5:0] t);
        logic live;
        live = !t[5] && busy[t[4:0]];
`ifdef ROB_BYPASS_EN
        if (live && !rdy[t[4:0]] && cdb_valid && cdb_tag == t) return {1'b1, cdb_data};
        if (live && !rdy[t[4:0]] && cdb2_valid && cdb2_tag == t) return {1'b1, cdb2_data};
`endif
        return (live && rdy[t[4:0]]) ? {1'b1, data_q[t[4:0]]} : 33'd0;
    endfunction

    always_comb begin
        {lk1_ready, lk1_value} = lookup(lk1_tag);
        {lk2_ready, lk2_value} = lookup(lk2_tag);
    end
endmodule

// File: tb/tb_rob_unit.sv
// tb_rob_unit: directed self-checking bench for rob_unit (default and ROB_BYPASS_EN builds).
module tb_rob_unit;
    logic        clock, reset, flush;
    logic        alloc_valid;
    logic [4:0]  alloc_rd;
    logic        alloc_ready;
    logic [5:0]  alloc_tag;
    logic        cdb_valid, cdb2_valid;
    logic [5:0]  cdb_tag, cdb2_tag;
    logic [31:0] cdb_data, cdb2_data;
    logic [5:0]  lk1_tag, lk2_tag;
    logic        lk1_ready, lk2_ready;
    logic [31:0] lk1_value, lk2_value;
    logic        commit_valid;
    logic [4:0]  commit_rd;
    logic [5:0]  commit_tag;
    logic [31:0] commit_data;
    logic [5:0]  count;
    logic        empty;
    int          vectors = 0;
    int          errors = 0;

    rob_unit dut (
        .clock(clock), .reset(reset), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .cdb2_valid(cdb2_valid), .cdb2_tag(cdb2_tag), .cdb2_data(cdb2_data),
        .lk1_tag(lk1_tag), .lk2_tag(lk2_tag), .lk1_ready(lk1_ready), .lk2_ready(lk2_ready),
        .lk1_value(lk1_value), .lk2_value(lk2_value),
        .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_tag(commit_tag), .commit_data(commit_data),
        .count(count), .empty(empty)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic idle;
        flush = 0; alloc_valid = 0; alloc_rd = 0;
        cdb_valid = 0; cdb_tag = 6'd32; cdb_data = 0;
        cdb2_valid = 0; cdb2_tag = 6'd32; cdb2_data = 0;
    endtask

    task automatic cdb1(input logic [5:0] t, input logic [31:0] d);
        cdb_valid = 1; cdb_tag = t; cdb_data = d;
    endtask

    task automatic cdb2(input logic [5:0] t, input logic [31:0] d);
        cdb2_valid = 1; cdb2_tag = t; cdb2_data = d;
    endtask

    task automatic do_flush;
        flush = 1;
        tick;
        flush = 0;
    endtask

    task automatic alloc_n(input int n, input logic [4:0] rd0);
        alloc_valid = 1;
        for (int i = 0; i < n; i++) begin
            alloc_rd = rd0 + 5'(i);
            tick;
        end
        alloc_valid = 0;
    endtask

    initial begin
        idle;
        reset = 1; lk1_tag = 0; lk2_tag = 0;
        #1;
        check("rst_alloc_ready", alloc_ready, 1);
        check("rst_alloc_tag", alloc_tag, 0);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_commit_valid", commit_valid, 0);
        check("rst_commit_tag", commit_tag, 6'd32);
        check("rst_lk1_ready", lk1_ready, 0);
        #11 reset = 0;
        tick;

        // single allocate, writeback, retire
        alloc_n(1, 5'd5);
        check("t1_alloc_tag", alloc_tag, 1);
        check("t1_count", count, 1);
        check("t1_empty", empty, 0);
        cdb1(0, 32'h1234);
        tick;
        idle;
        check("t1_lk1_ready", lk1_ready, 1);
        check("t1_lk1_value", lk1_value, 32'h1234);
        check("t1_no_commit_yet", commit_valid, 0);
        tick;
        check("t1_commit_valid", commit_valid, 1);
        check("t1_commit_rd", commit_rd, 5);
        check("t1_commit_tag", commit_tag, 0);
        check("t1_commit_data", commit_data, 32'h1234);
        check("t1_empty_after", empty, 1);
        tick;
        check("t1_commit_drop", commit_valid, 0);
        check("t1_commit_hold", commit_data, 32'h1234);

        // out-of-order completion, in-order retire
        do_flush;
        check("t2_flush_tag", alloc_tag, 0);
        alloc_n(3, 5'd10);
        check("t2_count", count, 3);
        cdb1(2, 32'h22); tick;
        check("t2_wait_a", commit_valid, 0);
        cdb1(1, 32'h11); tick;
        check("t2_wait_b", commit_valid, 0);
        cdb1(0, 32'h10); tick;
        idle;
        check("t2_wait_c", commit_valid, 0);
        tick;
        check("t2_c0_valid", commit_valid, 1);
        check("t2_c0_tag", commit_tag, 0);
        check("t2_c0_data", commit_data, 32'h10);
        tick;
        check("t2_c1_valid", commit_valid, 1);
        check("t2_c1_tag", commit_tag, 1);
        check("t2_c1_rd", commit_rd, 11);
        tick;
        check("t2_c2_tag", commit_tag, 2);
        check("t2_c2_data", commit_data, 32'h22);
        tick;
        check("t2_done_valid", commit_valid, 0);
        check("t2_done_empty", empty, 1);

        // full buffer, blocked alloc, commit+alloc same edge, wrap
        do_flush;
        alloc_n(32, 5'd0);
        check("t3_full_count", count, 32);
        check("t3_full_ready", alloc_ready, 0);
        check("t3_full_tag", alloc_tag, 0);
        alloc_valid = 1; alloc_rd = 7;
        tick;
        check("t3_ignored_count", count, 32);
        cdb1(0, 32'h5);
        tick;
        cdb_valid = 0;
        check("t3_still_full", count, 32);
        tick;
        check("t3_commit_valid", commit_valid, 1);
        check("t3_commit_tag", commit_tag, 0);
        check("t3_no_same_cycle_alloc", count, 31);
        check("t3_tag_unchanged", alloc_tag, 0);
        tick;
        idle;
        check("t3_wrap_tag", alloc_tag, 1);
        check("t3_wrap_count", count, 32);
        lk1_tag = 0;
        #1;
        check("t3_new_entry_not_ready", lk1_ready, 0);

        // dual-CDB collision, port 1 wins
        do_flush;
        alloc_n(4, 5'd1);
        cdb1(3, 32'hAAAA); cdb2(3, 32'hBBBB);
        tick;
        lk1_tag = 3;
        #1;
        check("t4_lk1_ready", lk1_ready, 1);
        check("t4_lk1_value", lk1_value, 32'hAAAA);
        cdb1(0, 32'hA0); cdb2(1, 32'hB1);
        tick;
        check("t4_wait", commit_valid, 0);
        cdb2_valid = 0; cdb1(2, 32'hC2);
        lk2_tag = 1;
        tick;
        idle;
        check("t4_lk2_value", lk2_value, 32'hB1);
        check("t4_c0_data", commit_data, 32'hA0);
        check("t4_c0_rd", commit_rd, 1);
        tick;
        check("t4_c1_data", commit_data, 32'hB1);
        tick;
        check("t4_c2_data", commit_data, 32'hC2);
        tick;
        check("t4_c3_tag", commit_tag, 3);
        check("t4_c3_data", commit_data, 32'hAAAA);
        check("t4_c3_rd", commit_rd, 4);
        check("t4_empty", empty, 1);
        cdb1(5, 32'h99); cdb2(6'd32, 32'h98);
        tick;
        idle;
        lk1_tag = 5;
        #1;
        check("t4_free_lk_ready", lk1_ready, 0);
        check("t4_free_lk_value", lk1_value, 0);
        check("t4_free_count", count, 0);
        check("t4_free_commit", commit_valid, 0);

        // flush overrides alloc and writeback
        alloc_n(4, 5'd20);
        flush = 1; alloc_valid = 1; cdb1(4, 32'h44);
        tick;
        idle;
        check("t5_flush_count", count, 0);
        check("t5_flush_tag", alloc_tag, 0);
        check("t5_flush_commit", commit_valid, 0);
        tick;
        lk1_tag = 4;
        #1;
        check("t5_dropped_commit", commit_valid, 0);
        check("t5_dropped_lk", lk1_ready, 0);

        // async reset while a commit pulse is high
        tick;
        alloc_n(1, 5'd9);
        cdb1(0, 32'h55);
        tick;
        idle;
        tick;
        check("t5_pre_reset_commit", commit_valid, 1);
        #2 reset = 1;
        #1;
        check("t5_async_commit", commit_valid, 0);
        check("t5_async_tag", commit_tag, 6'd32);
        check("t5_async_data", commit_data, 0);
        check("t5_async_count", count, 0);
        #2 reset = 0;
        tick;
        check("t5_post_reset_tag", alloc_tag, 0);

        // same-cycle CDB forwarding to lookup
        alloc_n(5, 5'd0);
        lk1_tag = 4;
        cdb1(4, 32'h77);
        #1;
`ifdef ROB_BYPASS_EN
        check("t6_bypass_ready", lk1_ready, 1);
        check("t6_bypass_value", lk1_value, 32'h77);
`else
        check("t6_nobypass_ready", lk1_ready, 0);
        check("t6_nobypass_value", lk1_value, 0);
`endif
        tick;
        idle;
        check("t6_next_ready", lk1_ready, 1);
        check("t6_next_value", lk1_value, 32'h77);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
